// File: rtl/gradient_magnitude_seq.sv
// Sequential gradient magnitude: |(gx,gy)| as floor L2 (bit-serial root) or L1, saturated to OUT_W bits.
// Optional GRAD_THRESH_EN adds thresh input and edge_hit output (edge is a reserved word).
module gradient_magnitude_seq #(
    parameter int unsigned IN_W   = 11,
    parameter int unsigned OUT_W  = 8,
    parameter int unsigned USE_L1 = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [IN_W-1:0] gx,
    input  logic signed [IN_W-1:0] gy,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W-1:0]       g,
`ifdef GRAD_THRESH_EN
    input  logic [OUT_W-1:0]       thresh,
    output logic                   edge_hit,
`endif
    output logic                   busy
);

    localparam int unsigned SQ_W  = 2 * IN_W;
    localparam int unsigned R_W   = IN_W;
    localparam int unsigned REM_W = R_W + 3;
    localparam int unsigned RES_W = R_W + 1;
    localparam int unsigned CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int unsigned G_MAX = (1 << OUT_W) - 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SQUARE = 2'd1;
    localparam logic [1:0] ROOT   = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0]       state_q, state_nx;
    logic [CNT_W-1:0] cnt_q, cnt_nx;
    logic [IN_W-1:0]  ax_q, ax_nx, ay_q, ay_nx;
    logic [SQ_W-1:0]  sq_q, sq_nx;
    logic [REM_W-1:0] rem_q, rem_nx;
    logic [R_W-1:0]   root_q, root_nx;
    logic [RES_W-1:0] res_q, res_nx;
    logic             in_ready_nx, out_valid_nx, busy_nx;
    logic [OUT_W-1:0] g_nx;

    logic [IN_W-1:0]  ax_c, ay_c;
    logic [REM_W-1:0] rem_sh_c, trial_c;
    logic [OUT_W-1:0] g_sat_c;

`ifdef GRAD_THRESH_EN
    logic [OUT_W-1:0] thresh_q, thresh_nx;
    logic             edge_nx;
`endif

    // Magnitude of the most negative input fits unsigned IN_W bits without overflow.
    assign ax_c = gx[IN_W-1] ? IN_W'(~gx + IN_W'(1)) : IN_W'(gx);
    assign ay_c = gy[IN_W-1] ? IN_W'(~gy + IN_W'(1)) : IN_W'(gy);

    assign rem_sh_c = {rem_q[REM_W-3:0], sq_q[SQ_W-1 -: 2]};
    assign trial_c  = REM_W'({root_q, 2'b01});
    assign g_sat_c  = (res_q > RES_W'(G_MAX)) ? OUT_W'(G_MAX) : OUT_W'(res_q);

    // State and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ax_q      <= '0;
            ay_q      <= '0;
            sq_q      <= '0;
            rem_q     <= '0;
            root_q    <= '0;
            res_q     <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            g         <= '0;
            busy      <= 1'b0;
`ifdef GRAD_THRESH_EN
            thresh_q  <= '0;
            edge_hit  <= 1'b0;
`endif
        end else begin
            state_q   <= state_nx;
            cnt_q     <= cnt_nx;
            ax_q      <= ax_nx;
            ay_q      <= ay_nx;
            sq_q      <= sq_nx;
            rem_q     <= rem_nx;
            root_q    <= root_nx;
            res_q     <= res_nx;
            in_ready  <= in_ready_nx;
            out_valid <= out_valid_nx;
            g         <= g_nx;
            busy      <= busy_nx;
`ifdef GRAD_THRESH_EN
            thresh_q  <= thresh_nx;
            edge_hit  <= edge_nx;
`endif
        end
    end

    // Next state, datapath and outputs.
    always_comb begin
        state_nx     = state_q;
        cnt_nx       = cnt_q;
        ax_nx        = ax_q;
        ay_nx        = ay_q;
        sq_nx        = sq_q;
        rem_nx       = rem_q;
        root_nx      = root_q;
        res_nx       = res_q;
        out_valid_nx = 1'b0;
        g_nx         = g;
`ifdef GRAD_THRESH_EN
        thresh_nx    = thresh_q;
        edge_nx      = edge_hit;
`endif

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    ax_nx    = ax_c;
                    ay_nx    = ay_c;
`ifdef GRAD_THRESH_EN
                    thresh_nx = thresh;
`endif
                    state_nx = SQUARE;
                end
            end
            SQUARE: begin
                if (USE_L1 != 0) begin
                    res_nx   = RES_W'(ax_q) + RES_W'(ay_q);
                    state_nx = DONE;
                end else begin
                    sq_nx    = SQ_W'(ax_q) * SQ_W'(ax_q) + SQ_W'(ay_q) * SQ_W'(ay_q);
                    rem_nx   = '0;
                    root_nx  = '0;
                    cnt_nx   = CNT_W'(IN_W - 1);
                    state_nx = ROOT;
                end
            end
            ROOT: begin
                // One restoring step: bring down two radicand bits, try root*4+1.
                sq_nx = sq_q << 2;
                if (rem_sh_c >= trial_c) begin
                    rem_nx  = rem_sh_c - trial_c;
                    root_nx = {root_q[R_W-2:0], 1'b1};
                end else begin
                    rem_nx  = rem_sh_c;
                    root_nx = {root_q[R_W-2:0], 1'b0};
                end
                if (cnt_q == '0) begin
                    res_nx   = RES_W'(root_nx);
                    state_nx = DONE;
                end else begin
                    cnt_nx = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                if (out_valid && out_ready) begin
                    state_nx = IDLE;
                end else begin
                    out_valid_nx = 1'b1;
                    g_nx         = g_sat_c;
`ifdef GRAD_THRESH_EN
                    edge_nx      = (g_sat_c >= thresh_q);
`endif
                end
            end
            default: state_nx = IDLE;
        endcase

        in_ready_nx = (state_nx == IDLE);
        busy_nx     = (state_nx != IDLE);
    end

endmodule
